bus_master_6502: RTL and testbench

- Bus initiator for the 6502-side system bus; it is the counterpart to the memory and peripheral responders on that bus.
- Converts single-beat FPGA-side requests (valid/ready) into complete 6502-style bus cycles: PHI1 address phase, then PHI2 data phase.
- Drives address, rwb, write data and phi2. Samples read data and returns it.
- Used for DMA, boot-loading and bench stimulus while the CPU is halted. The `bus_grant` input indicates the CPU is halted.

---
 rtl/bus_master_6502_if.sv | 70 +++++++
 rtl/bus_master_6502.sv | 153 +++++++++++++++
 tb/tb_bus_master_6502.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_6502_if.sv
// ============================================================================
// Module      : bus_master_6502_if
// Description : Request/response handshake and 6502 system-bus signals shared
//               by the bus initiator and whatever drives or observes it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_master_6502_if;
  // Ownership and request channel
  logic        bus_grant;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;

  // Response channel
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;

  // 6502-side bus
  logic [15:0] bus_addr;
  logic        bus_rwb;
  logic [7:0]  bus_data_out;
  logic [7:0]  bus_data_oe;
  logic [7:0]  bus_data_in;
  logic        bus_phi2;
  logic        busy;

  // The bus initiator itself
  modport master (
    input  bus_grant,
    input  req_valid,
    input  req_write,
    input  req_addr,
    input  req_wdata,
    input  bus_data_in,
    output req_ready,
    output rsp_valid,
    output rsp_rdata,
    output bus_addr,
    output bus_rwb,
    output bus_data_out,
    output bus_data_oe,
    output bus_phi2,
    output busy
  );

  // Request source plus bus responder side
  modport slave (
    output bus_grant,
    output req_valid,
    output req_write,
    output req_addr,
    output req_wdata,
    output bus_data_in,
    input  req_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  bus_addr,
    input  bus_rwb,
    input  bus_data_out,
    input  bus_data_oe,
    input  bus_phi2,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/bus_master_6502.sv
// ============================================================================
// Module      : bus_master_6502
// Description : Turns single-beat valid/ready requests into complete 6502 bus
//               cycles (PHI1 address phase, PHI2 data phase, one hold cycle)
//               while the CPU is halted and the bus is granted to this block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_master_6502 #(
  parameter int DIV_HALF = 12,  // clk_50 cycles per phi2 half-period
  parameter int CNT_W    = 8    // phase counter width, 2**CNT_W > DIV_HALF
) (
  input  logic              clk_50,
  input  logic              resetb,
  bus_master_6502_if.master bm
);

  // Parameter sanity checks, evaluated at elaboration
  generate
    if (DIV_HALF < 2) begin : g_div_half_check
      $error("bus_master_6502: DIV_HALF must be at least 2");
    end
    if ((DIV_HALF >> CNT_W) != 0) begin : g_cnt_w_check
      $error("bus_master_6502: CNT_W too narrow for DIV_HALF");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    RSP  = 2'd3
  } state_t;

  // Counter reload value: each half-period spans DIV_HALF cycles (N-1 .. 0)
  localparam logic [CNT_W-1:0] c_reload = CNT_W'(DIV_HALF - 1);
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_write;
  logic [7:0]       r_wdata;

  logic             r_phi2;
  logic             r_rwb;
  logic [15:0]      r_addr;
  logic [7:0]       r_data_out;
  logic [7:0]       r_data_oe;
  logic             r_rsp_valid;
  logic [7:0]       r_rsp_rdata;
  logic             r_busy;

  logic             w_idle;
  logic             w_accept;

  // Ready depends only on state and grant, never on req_valid
  assign w_idle       = (r_state == IDLE);
  assign bm.req_ready = w_idle & bm.bus_grant;
  assign w_accept     = bm.req_ready & bm.req_valid;

  assign bm.bus_phi2     = r_phi2;
  assign bm.bus_rwb      = r_rwb;
  assign bm.bus_addr     = r_addr;
  assign bm.bus_data_out = r_data_out;
  assign bm.bus_data_oe  = r_data_oe;
  assign bm.rsp_valid    = r_rsp_valid;
  assign bm.rsp_rdata    = r_rsp_rdata;
  assign bm.busy         = r_busy;

  // Bus-cycle sequencer; every bus and response output is registered here
  always_ff @(posedge clk_50 or negedge resetb) begin
    if (!resetb) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_wdata     <= 8'h00;
      r_phi2      <= 1'b0;
      r_rwb       <= 1'b1;
      r_addr      <= 16'h0000;
      r_data_out  <= 8'h00;
      r_data_oe   <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // Bus parked: reading, not driving data, address left as it was
          r_phi2    <= 1'b0;
          r_rwb     <= 1'b1;
          r_data_oe <= 8'h00;
          if (w_accept) begin
            // Latch every request field so later changes upstream are ignored
            r_addr  <= bm.req_addr;
            r_rwb   <= ~bm.req_write;
            r_write <= bm.req_write;
            r_wdata <= bm.req_wdata;
            r_cnt   <= c_reload;
            r_busy  <= 1'b1;
            r_state <= PH1;
          end
        end

        PH1: begin
          if (r_cnt == '0) begin
            // Raise phi2; writes drive the data bus for the whole high phase
            r_cnt  <= c_reload;
            r_phi2 <= 1'b1;
            if (r_write) begin
              r_data_oe  <= 8'hFF;
              r_data_out <= r_wdata;
            end
            r_state <= PH2;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end

        PH2: begin
          if (r_cnt == '0) begin
            // Read data is captured only on the last cycle of phi2 high
            if (!r_write) begin
              r_rsp_rdata <= bm.bus_data_in;
            end
            r_phi2      <= 1'b0;
            r_data_oe   <= 8'h00;
            r_data_out  <= 8'h00;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end else begin
            r_cnt <= r_cnt - c_one;
          end
        end

        RSP: begin
          // Address and rwb were held through this cycle for hold time
          r_rwb   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_master_6502.sv
// ============================================================================
// Module      : tb_bus_master_6502
// Description : Self-checking bench for bus_master_6502 (DIV_HALF=12 and 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_master_6502;

  localparam int D  = 12;
  localparam int D2 = 2;

  logic clk_50 = 1'b0;
  logic resetb;

  always #5 clk_50 = ~clk_50;

  bus_master_6502_if bif ();
  bus_master_6502_if bif2 ();

  bus_master_6502 #(.DIV_HALF(D), .CNT_W(8)) dut (
    .clk_50 (clk_50),
    .resetb (resetb),
    .bm     (bif.master)
  );

  bus_master_6502 #(.DIV_HALF(D2), .CNT_W(2)) dut2 (
    .clk_50 (clk_50),
    .resetb (resetb),
    .bm     (bif2.master)
  );

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic [7:0]  exp_rdata;
  } txn_t;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] last_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // {phi2, rwb, oe, dout, rsp_valid, busy, addr}
  function automatic logic [35:0] obs_main();
    return {bif.bus_phi2, bif.bus_rwb, bif.bus_data_oe, bif.bus_data_out,
            bif.rsp_valid, bif.busy, bif.bus_addr};
  endfunction

  function automatic logic [35:0] obs_d2();
    return {bif2.bus_phi2, bif2.bus_rwb, bif2.bus_data_oe, bif2.bus_data_out,
            bif2.rsp_valid, bif2.busy, bif2.bus_addr};
  endfunction

  function automatic logic [35:0] exp_vec(input logic phi2, input logic rwb,
                                          input logic [7:0] oe, input logic [7:0] dout,
                                          input logic rv, input logic busy,
                                          input logic [15:0] addr);
    return {phi2, rwb, oe, dout, rv, busy, addr};
  endfunction

  // One full transaction on the DIV_HALF=12 instance, checked every cycle
  task automatic run_txn(input txn_t t, input string tag);
    logic       ph2, inc;
    logic [7:0] oe;
    @(negedge clk_50);
    bif.req_valid   = 1'b1;
    bif.req_write   = t.write;
    bif.req_addr    = t.addr;
    bif.req_wdata   = t.wdata;
    bif.bus_data_in = ~t.din;
    #1 chk({tag, " ready"}, bif.req_ready, 1'b1);
    for (int c = 1; c <= 2*D+2; c++) begin
      @(negedge clk_50);
      if (c == 1) begin
        // Scramble request fields after accept; latched values must persist
        bif.req_valid = 1'b0;
        bif.req_addr  = ~t.addr;
        bif.req_wdata = ~t.wdata;
        bif.req_write = ~t.write;
      end
      ph2 = (c > D) && (c <= 2*D);
      inc = (c <= 2*D+1);
      oe  = (ph2 && t.write) ? 8'hFF : 8'h00;
      chk($sformatf("%s c%0d", tag, c), obs_main(),
          exp_vec(ph2, inc ? ~t.write : 1'b1, oe, (ph2 && t.write) ? t.wdata : 8'h00,
                  c == 2*D+1, inc, t.addr));
      if (c == 2*D+1 && !t.write) last_rdata = t.exp_rdata;
      if (c >= 2*D+1) chk($sformatf("%s rdata c%0d", tag, c), bif.rsp_rdata, last_rdata);
      bif.bus_data_in = (c == 2*D) ? t.din : ~t.din;
    end
  endtask

  txn_t vecs [5];

  initial begin
    int first_rsp, second_rsp, acc2, rsp_c, rv_seen;
    logic [7:0]  rd1, rd2;
    logic [15:0] addr26, addr27;

    vecs[0] = '{1'b0, 16'hFFFC, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 16'h0200, 8'h3C, 8'h00, 8'h00};
    vecs[2] = '{1'b0, 16'h1234, 8'h00, 8'h5A, 8'h5A};
    vecs[3] = '{1'b1, 16'hFFFF, 8'hFF, 8'h00, 8'h00};
    vecs[4] = '{1'b0, 16'h0000, 8'h00, 8'h00, 8'h00};

    resetb = 1'b0;
    bif.bus_grant = 1'b1;  bif.req_valid = 1'b0; bif.req_write = 1'b0;
    bif.req_addr  = 16'h0; bif.req_wdata = 8'h0; bif.bus_data_in = 8'h0;
    bif2.bus_grant = 1'b0; bif2.req_valid = 1'b0; bif2.req_write = 1'b0;
    bif2.req_addr  = 16'h0; bif2.req_wdata = 8'h0; bif2.bus_data_in = 8'h0;
    last_rdata = 8'h00;

    // Reset values
    repeat (2) @(negedge clk_50);
    chk("reset outputs", obs_main(), exp_vec(0, 1, 8'h00, 8'h00, 0, 0, 16'h0000));
    chk("reset rdata", bif.rsp_rdata, 8'h00);
    chk("reset ready", bif.req_ready, 1'b1);
    chk("reset outputs d2", obs_d2(), exp_vec(0, 1, 8'h00, 8'h00, 0, 0, 16'h0000));
    resetb = 1'b1;

    // Table-driven transactions
    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back reads with req_valid held high
    @(negedge clk_50);
    bif.req_valid = 1'b1; bif.req_write = 1'b0; bif.req_addr = 16'h1000;
    bif.bus_data_in = 8'hEE;
    #1 chk("b2b ready0", bif.req_ready, 1'b1);
    first_rsp = -1; second_rsp = -1; acc2 = -1;
    rd1 = 8'h00; rd2 = 8'h00; addr26 = 16'h0; addr27 = 16'h0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_50);
      if (c == 1) bif.req_addr = 16'h1001;
      if (bif.rsp_valid) begin
        if (first_rsp < 0) begin first_rsp = c; rd1 = bif.rsp_rdata; end
        else if (second_rsp < 0) begin second_rsp = c; rd2 = bif.rsp_rdata; end
      end
      if (c == 26) addr26 = bif.bus_addr;
      if (c == 27) addr27 = bif.bus_addr;
      if (acc2 >= 0 && c == acc2 + 1) bif.req_valid = 1'b0;
      if (c > 1 && acc2 < 0 && bif.req_ready) acc2 = c;
      bif.bus_data_in = (c == 24) ? 8'h11 : (c == 50) ? 8'h22 : 8'hEE;
    end
    chk("b2b rsp1 cycle", first_rsp, 25);
    chk("b2b rsp1 rdata", rd1, 8'h11);
    chk("b2b accept2 cycle", acc2, 26);
    chk("b2b addr hold c26", addr26, 16'h1000);
    chk("b2b addr c27", addr27, 16'h1001);
    chk("b2b rsp2 cycle", second_rsp, 51);
    chk("b2b rsp2 rdata", rd2, 8'h22);
    last_rdata = 8'h22;

    // No grant: request must not be accepted
    @(negedge clk_50);
    bif.bus_grant = 1'b0; bif.req_valid = 1'b1; bif.req_write = 1'b0;
    bif.req_addr = 16'h4000; bif.bus_data_in = 8'h00;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("nogrant ready %0d", k), bif.req_ready, 1'b0);
      chk($sformatf("nogrant idle %0d", k), {bif.busy, bif.bus_phi2}, 2'b00);
      @(negedge clk_50);
    end

    // Grant returns, then drops during PH2: cycle must still finish
    bif.bus_grant = 1'b1;
    #1 chk("grant ready", bif.req_ready, 1'b1);
    rsp_c = -1;
    for (int c = 1; c <= 27; c++) begin
      @(negedge clk_50);
      if (c == 15) bif.bus_grant = 1'b0;
      if (bif.rsp_valid && rsp_c < 0) begin
        rsp_c = c;
        chk("grantdrop rdata", bif.rsp_rdata, 8'h77);
      end
      if (c == 26) chk("grantdrop ready c26", bif.req_ready, 1'b0);
      if (c == 27) chk("grantdrop idle c27", {bif.busy, bif.bus_addr}, {1'b0, 16'h4000});
      bif.bus_data_in = (c == 24) ? 8'h77 : 8'h00;
    end
    chk("grantdrop rsp cycle", rsp_c, 25);
    last_rdata = 8'h77;
    bif.req_valid = 1'b0;
    @(negedge clk_50);
    bif.bus_grant = 1'b1;

    // Asynchronous reset in the middle of a write
    @(negedge clk_50);
    bif.req_valid = 1'b1; bif.req_write = 1'b1; bif.req_addr = 16'h0200;
    bif.req_wdata = 8'h3C;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk_50);
      if (c == 1) bif.req_valid = 1'b0;
      if (c == 14) chk("rst pre write oe", bif.bus_data_oe, 8'hFF);
    end
    resetb = 1'b0;
    #1 chk("rst async outputs", obs_main(), exp_vec(0, 1, 8'h00, 8'h00, 0, 0, 16'h0000));
    chk("rst async rdata", bif.rsp_rdata, 8'h00);
    last_rdata = 8'h00;
    rv_seen = 0;
    repeat (2) begin
      @(negedge clk_50);
      if (bif.rsp_valid) rv_seen++;
    end
    resetb = 1'b1;
    repeat (14) begin
      @(negedge clk_50);
      if (bif.rsp_valid) rv_seen++;
    end
    chk("rst no rsp_valid", rv_seen, 0);
    run_txn('{1'b0, 16'hBEEF, 8'h00, 8'hC3, 8'hC3}, "post_rst");

    // DIV_HALF=2 instance: short read
    @(negedge clk_50);
    bif2.bus_grant = 1'b1; bif2.req_valid = 1'b1; bif2.req_write = 1'b0;
    bif2.req_addr = 16'hABCD; bif2.bus_data_in = 8'h69;
    #1 chk("d2 ready", bif2.req_ready, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_50);
      if (c == 1) bif2.req_valid = 1'b0;
      chk($sformatf("d2 c%0d", c), obs_d2(),
          exp_vec(c == 3 || c == 4, 1'b1, 8'h00, 8'h00, c == 5, c <= 5, 16'hABCD));
      if (c == 5) chk("d2 rdata", bif2.rsp_rdata, 8'h96);
      bif2.bus_data_in = (c == 4) ? 8'h96 : 8'h69;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
